// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, derived frame totals and a
// helper that sizes counters to the smallest width holding a maximum value.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Bits needed to represent 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: counts 0..MAX, advancing on inc and returning to 0 after MAX.
// wrap flags the increment that rolls the count over, so a second counter can
// be chained off it.
module wrap_counter
    import vga_pkg::*;
#(
    parameter  int MAX = 1,
    localparam int W   = cnt_width(MAX)
) (
    input  logic         clk_25,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign wrap = inc && (count == MAX_V);

    // Count register: clear wins over increment, and the terminal value rolls to 0.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing. A horizontal counter advances every pixel
// clock and a vertical counter advances on each line wrap. Every output is a
// registered decode of the counter values, so outputs trail the counters by one
// clock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk_25,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic [10:0] pxl_x,
    output logic [10:0] pxl_y,
    output logic        en,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int H_LEN      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW         = cnt_width(H_LEN - 1);
    localparam int VW         = cnt_width(V_LEN - 1);
    localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          frame_done;
    logic [31:0]   h_val;
    logic [31:0]   v_val;
    logic          h_vis;
    logic          v_vis;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          at_line;
    logic          at_origin;

    wrap_counter #(.MAX(H_LEN - 1)) u_h_cnt (
        .clk_25 (clk_25),
        .reset  (reset),
        .inc    (1'b1),
        .clear  (1'b0),
        .count  (h_cnt),
        .wrap   (h_wrap)
    );

    wrap_counter #(.MAX(V_LEN - 1)) u_v_cnt (
        .clk_25 (clk_25),
        .reset  (reset),
        .inc    (h_wrap),
        .clear  (1'b0),
        .count  (v_cnt),
        .wrap   (v_wrap)
    );

    // Decode the raw counter position into visibility, sync windows and line/frame markers.
    always_comb begin
        h_val     = 32'(h_cnt);
        v_val     = 32'(v_cnt);
        h_vis     = h_val < 32'(H_ACTIVE);
        v_vis     = v_val < 32'(V_ACTIVE);
        h_in_sync = (h_val >= 32'(H_SYNC_BEG)) && (h_val < 32'(H_SYNC_END));
        v_in_sync = (v_val >= 32'(V_SYNC_BEG)) && (v_val < 32'(V_SYNC_END));
        at_line   = (h_cnt == '0);
        at_origin = at_line && (v_cnt == '0);
    end

    // Register the decode; frame_done remembers a vertical wrap so the very first
    // frame after reset is not counted as a completed one.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            pxl_x       <= '0;
            pxl_y       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            en          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
        end else begin
            pxl_x       <= 11'(h_cnt);
            pxl_y       <= 11'(v_cnt);
            hsync       <= !h_in_sync;
            vsync       <= !v_in_sync;
            en          <= h_vis && v_vis;
            line_start  <= at_line;
            frame_start <= at_origin;
            frame_done  <= v_wrap;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign red   = '0;
    assign green = '0;
    assign blue  = '0;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, hsync pulse width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_25, in, 1, pixel clock; the only clock.
- reset, in, 1, asynchronous active-high reset.
- hsync, out, 1, horizontal sync, active low.
- vsync, out, 1, vertical sync, active low.
- pxl_x, out, 11, current horizontal count, 0..H_TOTAL-1.
- pxl_y, out, 11, current vertical count, 0..V_TOTAL-1.
- en, out, 1, high inside the visible area.
- line_start, out, 1, one-cycle pulse when pxl_x==0.
- frame_start, out, 1, one-cycle pulse when pxl_x==0 and pxl_y==0.
- frame_cnt, out, 16, number of completed frames.
- red, green, blue, out, 4 each, constant 0; these seed the display chain.

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-004 The internal h_cnt SHALL increment by 1 on every clk_25 edge and wrap from H_TOTAL-1 to 0.
REQ-005 The internal v_cnt SHALL increment only when h_cnt wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-006 All outputs SHALL be registered, decoded from the counter values of the previous cycle; latency is 1 clock.
REQ-007 pxl_x and pxl_y SHALL equal the counter values, including during blanking.
REQ-008 en SHALL be 1 iff pxl_x < H_ACTIVE and pxl_y < V_ACTIVE.
REQ-009 hsync SHALL be 0 iff H_ACTIVE+H_FP <= pxl_x < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-010 vsync SHALL be 0 iff V_ACTIVE+V_FP <= pxl_y < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults); it is line-aligned and independent of pxl_x.
REQ-011 line_start and frame_start SHALL be exactly 1 cycle wide; frame_start implies line_start.
REQ-012 frame_cnt SHALL increment by 1 on the output cycle showing pxl_x==0, pxl_y==0 for every frame except the first after reset, and SHALL wrap from 65535 to 0.
REQ-013 The counters SHALL use the minimum width that holds H_TOTAL-1 and V_TOTAL-1; outputs SHALL be zero-extended to 11 bits.
REQ-014 red, green and blue SHALL be tied to 0 at all times.

Reset
REQ-015 While reset=1, regardless of clk_25, the module SHALL hold:
- h_cnt=0, v_cnt=0, pxl_x=0, pxl_y=0.
- hsync=1, vsync=1.
- en=0, line_start=0, frame_start=0, frame_cnt=0.
REQ-016 On the first clk_25 edge after reset deasserts, outputs SHALL show pxl_x=0, pxl_y=0, en=1, line_start=1, frame_start=1, frame_cnt=0.
REQ-017 Reset asserted mid-frame SHALL return all outputs to their reset values immediately (asynchronously), with no partial sync pulse after release.

Structure
REQ-018 The default timing constants and the derived H_TOTAL and V_TOTAL SHALL live in the shared package vga_pkg.
REQ-019 The horizontal and vertical counters SHALL each be an instance of one sub-module, wrap_counter, with parameter MAX and inputs inc and clear, and outputs count and wrap.
REQ-020 No other sub-modules SHALL be used.

Verification
REQ-021 Reset check: hold reset 5 cycles, then release -> the next edge shows (0,0), en=1, frame_start=1, frame_cnt=0; hsync=vsync=1 during reset.
REQ-022 Horizontal timing check: run 1 line -> en high for 640 cycles; hsync low for exactly 96 cycles starting at pxl_x=656; line_start period is 800 cycles.
REQ-023 Vertical timing check: run 1 frame -> vsync low for 1600 cycles starting at pxl_y=490, pxl_x=0; frame_start period is 420000 cycles; en never high for pxl_y >= 480.
REQ-024 Wrap check: observe the transition (799,524) -> (0,0) -> frame_cnt increments on that cycle; preload frame_cnt to 65535 via force -> it wraps to 0.
REQ-025 Mid-operation reset check: assert reset at pxl_x=700, pxl_y=490 -> hsync and vsync go to 1 without waiting for a clock; on release, the sequence restarts as in REQ-021.
REQ-026 Small-parameter check: H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1 -> period is 7x5=35 cycles; hsync low at pxl_x=5; vsync low at pxl_y=3.
